// File: rtl/ps2_kbd.sv
// ps2_kbd: PS/2 keyboard front end.
//
// Synchronizes and filters the raw PS/2 pins, deserializes device-to-host
// frames (start, 8 data LSB first, odd parity, stop), decodes scan-code set 2
// into ASCII and produces the character / Enter / Esc event stream consumed by
// the passphrase buffer.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rst          asynchronous active-low reset
//   ps2_clk_i    raw PS/2 clock pin (asynchronous)
//   ps2_dat_i    raw PS/2 data pin (asynchronous)
//   ps2_data_o   ASCII byte, meaningful while ps2_valid_o is high, held after
//   ps2_valid_o  one-cycle event strobe
//   ps2_done_o   Enter flag: high with the strobe and for one cycle after it
//   ps2_reset_o  Esc flag, only ever high together with ps2_valid_o
//   err_o        one-cycle pulse on framing/parity error or frame timeout
module ps2_kbd #(
    parameter int FILT_LEN = 8,
    parameter int TIMEOUT  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] ps2_data_o,
    output logic       ps2_valid_o,
    output logic       ps2_done_o,
    output logic       ps2_reset_o,
    output logic       err_o
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0]    clk_s_q, dat_s_q;
    logic          clk_sync, dat_sync;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;

    assign clk_sync = clk_s_q[1];
    assign dat_sync = dat_s_q[1];

    // fcnt counts consecutive samples that disagree with the filtered level;
    // the FILT_LEN-th such sample flips the level, and a high-to-low flip is
    // the bit sample point in that same cycle.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fall   = 1'b0;
        if (clk_sync != filt_q) begin
            if (fcnt_q == FW'(FILT_LEN - 1)) begin
                filt_d = clk_sync;
                fall   = filt_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [1:0]    state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          good, ferr;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        par_d   = par_q;
        good    = 1'b0;
        ferr    = 1'b0;

        if (state_q == IDLE || fall) tcnt_d = '0;
        else                         tcnt_d = tcnt_q + TW'(1);

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!dat_sync) begin
                        state_d = DATA;
                        bcnt_d  = 3'd0;
                    end
                end
                DATA: begin
                    sh_d   = {dat_sync, sh_q[7:1]};
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_sync;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (dat_sync && (^{sh_q, par_q})) good = 1'b1;
                    else                              ferr = 1'b1;
                end
            endcase
        end else if (state_q != IDLE && tcnt_q == TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            ferr    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decoder
    // ------------------------------------------------------------------
    function automatic logic [7:0] map_ascii(input logic [7:0] code, input logic up);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20;
            default: a = 8'h00;
        endcase
        // Only letters have an upper-case form; 0x00 marks an unmapped code.
        if (up && a >= 8'h61 && a <= 8'h7A) a = a - 8'h20;
        return a;
    endfunction

    logic       brk_q, brk_d, ext_q, ext_d, shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, done_q, esc_q, err_q;
    logic       emit, enter, esc;
    logic       is_shift;
    logic [7:0] asc;

    assign is_shift = (sh_q == 8'h12) || (sh_q == 8'h59);
    assign asc      = map_ascii(sh_q, shift_q);

    // sh_q already holds the complete code during the STOP sample cycle, so
    // the decode happens in that cycle and the outputs register at its end.
    always_comb begin
        brk_d   = brk_q;
        ext_d   = ext_q;
        shift_d = shift_q;
        data_d  = data_q;
        emit    = 1'b0;
        enter   = 1'b0;
        esc     = 1'b0;
        if (good) begin
            if (sh_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (sh_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (is_shift) shift_d = 1'b0;
            end else if (ext_q) begin
                ext_d = 1'b0;
                if (sh_q == 8'h5A) begin
                    emit   = 1'b1;
                    enter  = 1'b1;
                    data_d = 8'h0D;
                end
            end else if (is_shift) begin
                shift_d = 1'b1;
            end else if (sh_q == 8'h5A) begin
                emit   = 1'b1;
                enter  = 1'b1;
                data_d = 8'h0D;
            end else if (sh_q == 8'h76) begin
                emit   = 1'b1;
                esc    = 1'b1;
                data_d = 8'h1B;
            end else if (asc != 8'h00) begin
                emit   = 1'b1;
                data_d = asc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s_q <= 2'b11;
            dat_s_q <= 2'b11;
            filt_q  <= 1'b1;
            fcnt_q  <= '0;
            state_q <= IDLE;
            bcnt_q  <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tcnt_q  <= '0;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            shift_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            esc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            clk_s_q <= {clk_s_q[0], ps2_clk_i};
            dat_s_q <= {dat_s_q[0], ps2_dat_i};
            filt_q  <= filt_d;
            fcnt_q  <= fcnt_d;
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tcnt_q  <= tcnt_d;
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= emit;
            // Enter: done rides with the strobe, then stays one more beat.
            done_q  <= enter | (done_q & valid_q);
            esc_q   <= esc;
            err_q   <= ferr;
        end
    end

    assign ps2_data_o  = data_q;
    assign ps2_valid_o = valid_q;
    assign ps2_done_o  = done_q;
    assign ps2_reset_o = esc_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_ps2_kbd.sv
`timescale 1ns/1ps
module tb_ps2_kbd;
    localparam int FILT = 8;
    localparam int TO   = 1000;
    localparam int HALF = 20;

    logic       clk = 1'b0, rst = 1'b0, pc = 1'b1, pd = 1'b1;
    logic [7:0] ps2_data_o;
    logic       ps2_valid_o, ps2_done_o, ps2_reset_o, err_o;

    always #5 clk = ~clk;

    ps2_kbd #(.FILT_LEN(FILT), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk_i(pc), .ps2_dat_i(pd),
        .ps2_data_o(ps2_data_o), .ps2_valid_o(ps2_valid_o),
        .ps2_done_o(ps2_done_o), .ps2_reset_o(ps2_reset_o), .err_o(err_o)
    );

    // One event = strobe cycle X plus the two following cycles.
    typedef struct packed {
        logic [7:0] data; logic done; logic rst; logic v1; logic d1; logic d2;
    } ev_t;
    typedef struct packed { logic [7:0] data; logic v; logic d; logic r; } smp_t;

    ev_t  obs[$], exp_q[$];
    smp_t h0 = '0, h1 = '0, h2 = '0;
    int   tests = 0, fails = 0, err_pulses = 0, err_hi = 0;
    logic err_prev = 1'b0;
    logic mbrk = 0, mext = 0, mshift = 0;

    logic [7:0] let_tab [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                 8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                 8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] dig_tab [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    logic [7:0] extra   [10] = '{8'h29,8'h12,8'h59,8'hF0,8'hE0,8'h5A,8'h76,8'h05,8'h7E,8'hF0};

    always @(negedge clk) begin
        ev_t e;
        h2 = h1; h1 = h0;
        h0.data = ps2_data_o; h0.v = ps2_valid_o; h0.d = ps2_done_o; h0.r = ps2_reset_o;
        if (h2.v) begin
            e.data = h2.data; e.done = h2.d; e.rst = h2.r;
            e.v1 = h1.v; e.d1 = h1.d; e.d2 = h0.d;
            obs.push_back(e);
        end
        if (err_o) err_hi++;
        if (err_o && !err_prev) err_pulses++;
        err_prev = err_o;
    end

    function automatic ev_t mk(input logic [7:0] d, input logic dn, input logic r);
        ev_t e;
        e.data = d; e.done = dn; e.rst = r; e.v1 = 1'b0; e.d1 = dn; e.d2 = 1'b0;
        return e;
    endfunction

    // Reference decoder: scan-code rules applied to one received code.
    task automatic model(input logic [7:0] c);
        logic shk;
        shk = (c == 8'h12) || (c == 8'h59);
        if (c == 8'hF0) mbrk = 1;
        else if (c == 8'hE0) mext = 1;
        else if (mbrk) begin mbrk = 0; mext = 0; if (shk) mshift = 0; end
        else if (mext) begin mext = 0; if (c == 8'h5A) exp_q.push_back(mk(8'h0D, 1, 0)); end
        else if (shk) mshift = 1;
        else if (c == 8'h5A) exp_q.push_back(mk(8'h0D, 1, 0));
        else if (c == 8'h76) exp_q.push_back(mk(8'h1B, 0, 1));
        else if (c == 8'h29) exp_q.push_back(mk(8'h20, 0, 0));
        else begin
            for (int i = 0; i < 26; i++)
                if (let_tab[i] == c) exp_q.push_back(mk((mshift ? 8'h41 : 8'h61) + 8'(i), 0, 0));
            for (int i = 0; i < 10; i++)
                if (dig_tab[i] == c) exp_q.push_back(mk(8'h30 + 8'(i), 0, 0));
        end
    endtask

    task automatic ps2_bit(input logic b);
        pd = b;
        repeat (HALF) @(negedge clk);
        pc = 1'b0;
        repeat (HALF) @(negedge clk);
        pc = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input bit badpar);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(c[i]);
        ps2_bit((~^c) ^ badpar);
        ps2_bit(1'b1);
        repeat (100) @(negedge clk);
        if (!badpar) model(c);
    endtask

    task automatic do_reset();
        rst = 1'b0; mbrk = 0; mext = 0; mshift = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({ps2_data_o, ps2_valid_o, ps2_done_o, ps2_reset_o, err_o} !== 12'h0) begin
            fails++;
            $display("FAIL reset_in: got %h %b%b%b%b want 00 0000", ps2_data_o,
                     ps2_valid_o, ps2_done_o, ps2_reset_o, err_o);
        end
        rst = 1'b1;
        repeat (20) @(negedge clk);
        tests++;
        if ({ps2_data_o, ps2_valid_o, ps2_done_o, ps2_reset_o, err_o} !== 12'h0) begin
            fails++;
            $display("FAIL reset_out: got %h %b%b%b%b want 00 0000", ps2_data_o,
                     ps2_valid_o, ps2_done_o, ps2_reset_o, err_o);
        end
    endtask

    task automatic test_a();
        obs.delete(); exp_q.delete();
        send_frame(8'h1C, 0); send_frame(8'hF0, 0); send_frame(8'h1C, 0);
        tests++;
        if (obs.size() != exp_q.size() || exp_q.size() != 1) begin
            fails++; $display("FAIL a_count: got %0d want 1", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++; $display("FAIL a_ev%0d: got %h want %h", i, obs[i], exp_q[i]);
            end
        end
        tests++;
        if (ps2_data_o !== 8'h61) begin
            fails++; $display("FAIL a_hold: got %h want 61", ps2_data_o);
        end
    endtask

    task automatic test_shift();
        obs.delete(); exp_q.delete();
        send_frame(8'h12, 0); send_frame(8'h1C, 0); send_frame(8'hF0, 0); send_frame(8'h1C, 0);
        send_frame(8'hF0, 0); send_frame(8'h12, 0); send_frame(8'h1C, 0);
        tests++;
        if (obs.size() != exp_q.size() || exp_q.size() != 2) begin
            fails++; $display("FAIL shift_count: got %0d want 2", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++; $display("FAIL shift_ev%0d: got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_enter_esc();
        obs.delete(); exp_q.delete();
        send_frame(8'h5A, 0);
        send_frame(8'hE0, 0); send_frame(8'h5A, 0);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h5A, 0);
        send_frame(8'h76, 0);
        tests++;
        if (obs.size() != exp_q.size() || exp_q.size() != 3) begin
            fails++; $display("FAIL enter_count: got %0d want 3", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++; $display("FAIL enter_ev%0d: got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_parity();
        int e0;
        obs.delete(); exp_q.delete(); e0 = err_pulses;
        send_frame(8'h1C, 1);
        send_frame(8'h16, 0);
        tests++;
        if (err_pulses - e0 != 1 || err_hi - 0 < 0) begin
            fails++; $display("FAIL par_err: got %0d pulses want 1", err_pulses - e0);
        end
        tests++;
        if (obs.size() != 1 || exp_q.size() != 1 || obs[0] !== exp_q[0]) begin
            fails++; $display("FAIL par_next: got %0d events want 1 of data 31", obs.size());
        end
    endtask

    task automatic test_timeout();
        int e0;
        obs.delete(); exp_q.delete(); e0 = err_pulses;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO + 50) @(negedge clk);
        tests++;
        if (err_pulses - e0 != 1) begin
            fails++; $display("FAIL timeout_err: got %0d pulses want 1", err_pulses - e0);
        end
        send_frame(8'h29, 0);
        tests++;
        if (obs.size() != 1 || exp_q.size() != 1 || obs[0] !== exp_q[0]) begin
            fails++; $display("FAIL timeout_next: got %0d events want 1 of data 20", obs.size());
        end
    endtask

    task automatic test_glitch();
        int e0;
        obs.delete(); exp_q.delete(); e0 = err_pulses;
        pd = 1'b0;
        repeat (5) begin
            repeat (20) @(negedge clk);
            pc = 1'b0;
            repeat (FILT - 1) @(negedge clk);
            pc = 1'b1;
        end
        repeat (20) @(negedge clk);
        pd = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h1C, 0);
        tests++;
        if (err_pulses != e0) begin
            fails++; $display("FAIL glitch_err: got %0d pulses want 0", err_pulses - e0);
        end
        tests++;
        if (obs.size() != 1 || exp_q.size() != 1 || obs[0] !== exp_q[0]) begin
            fails++; $display("FAIL glitch_ev: got %0d events want 1 of data 61", obs.size());
        end
    endtask

    task automatic test_mid_reset();
        int e0;
        obs.delete(); exp_q.delete();
        send_frame(8'h12, 0);
        ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
        do_reset();
        tests++;
        if ({ps2_valid_o, ps2_done_o, ps2_reset_o, err_o} !== 4'h0 || ps2_data_o !== 8'h00) begin
            fails++; $display("FAIL midrst_out: got %h %b%b%b%b want 00 0000", ps2_data_o,
                              ps2_valid_o, ps2_done_o, ps2_reset_o, err_o);
        end
        rst = 1'b1;
        e0 = err_pulses;
        repeat (TO + 50) @(negedge clk);
        send_frame(8'h1C, 0);
        tests++;
        if (err_pulses != e0) begin
            fails++; $display("FAIL midrst_err: got %0d pulses want 0", err_pulses - e0);
        end
        tests++;
        if (obs.size() != 1 || exp_q.size() != 1 || obs[0] !== exp_q[0]) begin
            fails++; $display("FAIL midrst_ev: got %0d events want 1 of data 61", obs.size());
        end
    endtask

    task automatic test_random();
        int e0, h0c, nbad;
        logic [7:0] c;
        bit bad;
        obs.delete(); exp_q.delete(); e0 = err_pulses; h0c = err_hi; nbad = 0;
        for (int n = 0; n < 30; n++) begin
            int k;
            k = $urandom_range(0, 45);
            if (k < 26) c = let_tab[k];
            else if (k < 36) c = dig_tab[k - 26];
            else c = extra[k - 36];
            bad = ($urandom_range(0, 7) == 0);
            if (bad) nbad++;
            send_frame(c, bad);
        end
        tests++;
        if (err_pulses - e0 != nbad || err_hi - h0c != nbad) begin
            fails++; $display("FAIL rnd_err: got %0d pulses %0d cycles want %0d",
                              err_pulses - e0, err_hi - h0c, nbad);
        end
        tests++;
        if (obs.size() != exp_q.size()) begin
            fails++; $display("FAIL rnd_count: got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++; $display("FAIL rnd_ev%0d: got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_a();
        test_shift();
        test_enter_esc();
        test_parity();
        test_timeout();
        test_glitch();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
